// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length codes, Nk/Nr lookup and byte/word helpers.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;
  localparam logic [1:0] KEY_LEN_BAD = 2'd3;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: nk_of = NK_128;
      KEY_LEN_192: nk_of = NK_192;
      KEY_LEN_256: nk_of = NK_256;
      default:     nk_of = NK_128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: nr_of = NR_128;
      KEY_LEN_192: nr_of = NR_192;
      KEY_LEN_256: nr_of = NR_256;
      default:     nr_of = NR_128;
    endcase
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    rotword = {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_expand_stream_if.sv
// Handshake bundle between a round-key consumer and the key expansion engine.
interface key_expand_stream_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] init_key;
  logic         rk_ready;
  logic [127:0] round_key;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;
  logic         err;

  modport master (
    output start, key_len, init_key, rk_ready,
    input  round_key, rk_valid, rk_idx, rk_last, busy, err
  );

  modport slave (
    input  start, key_len, init_key, rk_ready,
    output round_key, rk_valid, rk_idx, rk_last, busy, err
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] subst
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Square-and-multiply builds x^2 * x^4 * ... * x^128 = x^254, which maps 0 to 0.
  always_comb begin
    sq  = value;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/key_expand_stream.sv
// Streaming AES key expansion: one schedule word per cycle, round keys handed out with valid/ready.
module key_expand_stream
  import aes_pkg::*;
#(
  parameter bit SUPPORT_192   = 1'b1,
  parameter bit RST_KEY_CLEAR = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  key_expand_stream_if.slave ks
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]   state;
  logic [3:0]   nk;
  logic [3:0]   nr;
  logic [255:0] key_buf;
  logic [5:0]   word_idx;
  logic [3:0]   phase;
  logic [7:0]   rcon;
  logic [31:0]  win  [8];
  logic [31:0]  coll [4];
  logic [127:0] round_key_q;
  logic         rk_valid_q;
  logic [3:0]   rk_idx_q;
  logic         rk_last_q;
  logic         err_q;

  logic [2:0]   old_sel;
  logic [31:0]  prev_word;
  logic [31:0]  old_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp;
  logic [31:0]  new_word;
  logic         bad_len;
  logic         gen_last;

  // win[0] is always w[i-1]; w[i-Nk] therefore sits Nk-1 slots deeper.
  assign prev_word = win[0];
  assign old_sel   = 3'(nk - 4'd1);
  assign old_word  = win[old_sel];
  assign sub_in    = (phase == 4'd0) ? rotword(prev_word) : prev_word;
  assign bad_len   = (ks.key_len == KEY_LEN_BAD) || ((ks.key_len == KEY_LEN_192) && !SUPPORT_192);
  assign gen_last  = (word_idx[1:0] == 2'd3) && (word_idx[5:2] == nr);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .value (sub_in[8*g +: 8]),
      .subst (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    if (phase == 4'd0)
      temp = sub_out ^ {rcon, 24'h000000};
    else if ((nk == NK_256) && (phase == 4'd4))
      temp = sub_out;
    else
      temp = prev_word;
    new_word = (word_idx < {2'b00, nk}) ? key_buf[255:224] : (old_word ^ temp);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= ST_IDLE;
      nk          <= 4'd0;
      nr          <= 4'd0;
      word_idx    <= 6'd0;
      phase       <= 4'd0;
      rcon        <= 8'h00;
      round_key_q <= 128'h0;
      rk_valid_q  <= 1'b0;
      rk_idx_q    <= 4'd0;
      rk_last_q   <= 1'b0;
      err_q       <= 1'b0;
      if (RST_KEY_CLEAR) begin
        key_buf <= 256'h0;
        for (int k = 0; k < 8; k++) win[k] <= 32'h0;
        for (int k = 0; k < 4; k++) coll[k] <= 32'h0;
      end
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ks.start) begin
            if (bad_len) begin
              err_q <= 1'b1;
            end else begin
              nk       <= nk_of(ks.key_len);
              nr       <= nr_of(ks.key_len);
              key_buf  <= ks.init_key;
              word_idx <= 6'd0;
              phase    <= 4'd0;
              rcon     <= RCON_INIT;
              state    <= ST_GEN;
            end
          end
        end
        ST_GEN: begin
          win[0] <= new_word;
          for (int k = 1; k < 8; k++) win[k] <= win[k-1];
          coll[word_idx[1:0]] <= new_word;
          if (word_idx < {2'b00, nk}) key_buf <= {key_buf[223:0], 32'h0};
          if ((phase == 4'd0) && (word_idx >= {2'b00, nk})) rcon <= xtime(rcon);
          phase    <= (phase == nk - 4'd1) ? 4'd0 : phase + 4'd1;
          word_idx <= gen_last ? 6'd0 : word_idx + 6'd1;
          if (word_idx[1:0] == 2'd3) begin
            round_key_q <= {coll[0], coll[1], coll[2], new_word};
            rk_valid_q  <= 1'b1;
            rk_idx_q    <= word_idx[5:2];
            rk_last_q   <= (word_idx[5:2] == nr);
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ks.rk_ready) begin
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            state      <= rk_last_q ? ST_IDLE : ST_GEN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ks.round_key = round_key_q;
  assign ks.rk_valid  = rk_valid_q;
  assign ks.rk_idx    = rk_idx_q;
  assign ks.rk_last   = rk_last_q;
  assign ks.busy      = (state != ST_IDLE);
  assign ks.err       = err_q;

endmodule

// File: tb/tb_key_expand_stream.sv
// Directed bench for key_expand_stream: FIPS-197 schedules, backpressure, illegal lengths, mid-run reset.
module tb_key_expand_stream;
  import aes_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] exp128 [11];
  logic [127:0] got [15];
  int           got_cnt;

  key_expand_stream_if ks();
  key_expand_stream_if ks_no192();

  key_expand_stream #(.SUPPORT_192(1'b1), .RST_KEY_CLEAR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks.slave)
  );

  key_expand_stream #(.SUPPORT_192(1'b0), .RST_KEY_CLEAR(1'b0)) dut_no192 (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks_no192.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key);
    ks.key_len  = len;
    ks.init_key = key;
    ks.start    = 1'b1;
    step();
    ks.start    = 1'b0;
  endtask

  task automatic waitValid(input string tag, output int cycles);
    cycles = 0;
    while (!ks.rk_valid && cycles < 20) begin
      step();
      cycles++;
    end
    checkOutput(tag, 128'(ks.rk_valid), 128'(1));
  endtask

  // Runs one full expansion, checking index/last/latency per key and stability while stalled.
  task automatic collectKeys(input logic [1:0] len, input logic [255:0] key, input int nr, input bit stall);
    int           cycles;
    logic [127:0] held;
    logic [3:0]   held_idx;
    ks.rk_ready = !stall;
    applyStimulus(len, key);
    got_cnt = 0;
    for (int r = 0; r <= nr; r++) begin
      waitValid($sformatf("valid%0d", r), cycles);
      got[r] = ks.round_key;
      got_cnt++;
      checkOutput($sformatf("latency%0d", r), 128'(cycles), 128'(4));
      checkOutput($sformatf("rk_idx%0d", r), 128'(ks.rk_idx), 128'(r));
      checkOutput($sformatf("rk_last%0d", r), 128'(ks.rk_last), 128'(r == nr));
      if (stall) begin
        held     = ks.round_key;
        held_idx = ks.rk_idx;
        repeat ($urandom_range(0, 7)) begin
          ks.start    = 1'b1;
          ks.key_len  = KEY_LEN_128;
          ks.init_key = ~key;
          step();
          ks.start    = 1'b0;
          checkOutput("stall_key", ks.round_key, held);
          checkOutput("stall_idx", 128'(ks.rk_idx), 128'(held_idx));
          checkOutput("stall_valid", 128'(ks.rk_valid), 128'(1));
        end
      end
      ks.rk_ready = 1'b1;
      step();
      ks.rk_ready = !stall;
    end
    checkOutput("busy_end", 128'(ks.busy), 128'(0));
    repeat (6) step();
    checkOutput("no_extra_valid", 128'(ks.rk_valid), 128'(0));
    checkOutput("key_count", 128'(got_cnt), 128'(nr + 1));
  endtask

  initial begin
    int cycles;
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    ks.start = 1'b0;       ks.key_len = 2'd0;       ks.init_key = 256'h0;       ks.rk_ready = 1'b0;
    ks_no192.start = 1'b0; ks_no192.key_len = 2'd0; ks_no192.init_key = 256'h0; ks_no192.rk_ready = 1'b0;

    step();
    step();
    rst_n = 1'b0;
    checkOutput("rst_busy", 128'(ks.busy), 128'(0));
    checkOutput("rst_valid", 128'(ks.rk_valid), 128'(0));
    checkOutput("rst_last", 128'(ks.rk_last), 128'(0));
    checkOutput("rst_err", 128'(ks.err), 128'(0));
    checkOutput("rst_idx", 128'(ks.rk_idx), 128'(0));
    checkOutput("rst_key", ks.round_key, 128'h0);

    collectKeys(KEY_LEN_128, KEY128, 10, 1'b0);
    for (int r = 0; r <= 10; r++) checkOutput($sformatf("aes128_rk%0d", r), got[r], exp128[r]);

    collectKeys(KEY_LEN_192, KEY192, 12, 1'b0);
    checkOutput("aes192_rk0", got[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    checkOutput("aes192_rk1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    checkOutput("aes192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

    collectKeys(KEY_LEN_256, KEY256, 14, 1'b0);
    checkOutput("aes256_rk0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
    checkOutput("aes256_rk1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
    checkOutput("aes256_rk2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    checkOutput("aes256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

    collectKeys(KEY_LEN_256, KEY256, 14, 1'b1);
    checkOutput("bp256_rk0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
    checkOutput("bp256_rk1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
    checkOutput("bp256_rk2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    checkOutput("bp256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

    ks.key_len = KEY_LEN_BAD;
    ks.start   = 1'b1;
    ks_no192.key_len = KEY_LEN_192;
    ks_no192.start   = 1'b1;
    step();
    ks.start       = 1'b0;
    ks_no192.start = 1'b0;
    checkOutput("err_len3", 128'(ks.err), 128'(1));
    checkOutput("err_len3_busy", 128'(ks.busy), 128'(0));
    checkOutput("err_no192", 128'(ks_no192.err), 128'(1));
    checkOutput("err_no192_busy", 128'(ks_no192.busy), 128'(0));
    step();
    checkOutput("err_len3_pulse", 128'(ks.err), 128'(0));
    checkOutput("err_no192_pulse", 128'(ks_no192.err), 128'(0));
    checkOutput("err_len3_idle", 128'(ks.busy), 128'(0));

    ks.rk_ready = 1'b0;
    applyStimulus(KEY_LEN_128, KEY128);
    for (int r = 0; r < 5; r++) begin
      waitValid($sformatf("pre_rst_valid%0d", r), cycles);
      ks.rk_ready = 1'b1;
      step();
      ks.rk_ready = 1'b0;
    end
    waitValid("hold5_valid", cycles);
    checkOutput("hold5_idx", 128'(ks.rk_idx), 128'(5));
    checkOutput("hold5_key", ks.round_key, exp128[5]);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    checkOutput("abort_valid", 128'(ks.rk_valid), 128'(0));
    checkOutput("abort_busy", 128'(ks.busy), 128'(0));
    checkOutput("abort_key", ks.round_key, 128'h0);
    checkOutput("abort_idx", 128'(ks.rk_idx), 128'(0));
    repeat (8) step();
    checkOutput("abort_quiet", 128'(ks.rk_valid), 128'(0));

    collectKeys(KEY_LEN_128, KEY128, 10, 1'b0);
    for (int r = 0; r <= 10; r++) checkOutput($sformatf("rerun128_rk%0d", r), got[r], exp128[r]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/key_expand_stream.md
KEY_EXPAND_STREAM -- requirements
Module: key_expand_stream

Interface
REQ-001 SHALL have parameter SUPPORT_192, default 1, enabling AES-192 mode; when 0, key_len=1 is illegal.
REQ-002 SHALL have parameter RST_KEY_CLEAR, default 1; when 1, reset also zeroes the internal key-word window.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-high (asserted when 1).
REQ-005 start  input  1  request an expansion; sampled only in IDLE.
REQ-006 key_len  input  2  0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=illegal; sampled with start.
REQ-007 init_key  input  256  cipher key MSB-aligned; AES-128 uses [255:128], AES-192 uses [255:64]; sampled with start.
REQ-008 rk_ready  input  1  consumer accepts round key.
REQ-009 round_key  output  128  current round key, word w[4r] in [127:96].
REQ-010 rk_valid  output  1  round_key valid; held until accepted.
REQ-011 rk_idx  output  4  round number r of round_key (0..Nr).
REQ-012 rk_last  output  1  high with rk_valid when rk_idx==Nr.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  one-cycle pulse on illegal key_len at start.

Function
REQ-015 SHALL implement FSM states IDLE, GEN, HOLD.
REQ-016 IDLE: start with legal key_len SHALL latch key_len and init_key, clear word counter i, and go to GEN; start with illegal key_len SHALL pulse err next cycle and stay in IDLE.
REQ-017 GEN SHALL produce exactly one key word w[i] per cycle: w[i]=init word i for i<Nk; else w[i]=w[i-Nk] XOR temp, temp=SubWord(RotWord(w[i-1])) XOR Rcon[i/Nk] if i mod Nk==0, SubWord(w[i-1]) if Nk==8 and i mod 8==4, else w[i-1].
REQ-018 Each w[i] SHALL enter an 8-word sliding window (w[i-Nk] read from window slot selected by Nk) and a 4-word collector.
REQ-019 When the 4th collector word is written (i mod 4==3), the next cycle SHALL show rk_valid=1 with round_key, rk_idx=i/4, and FSM SHALL be in HOLD.
REQ-020 HOLD: generation stalls; round_key, rk_idx, rk_last stable while rk_valid && !rk_ready.
REQ-021 HOLD with rk_ready=1: rk_valid drops next cycle; if rk_last, go IDLE, else go GEN.
REQ-022 Latency: first rk_valid SHALL rise 4 cycles after the start-sampling edge; with rk_ready tied high, subsequent keys every 5 cycles.
REQ-023 Rcon SHALL be generated by GF(2^8) doubling from 0x01 (0x01..0x80, 0x1b, 0x36), reset at each start; SHALL never index beyond 10 values.
REQ-024 Total words SHALL be 4*(Nr+1) (44/52/60); i SHALL never exceed 59.
REQ-025 start while busy SHALL be ignored; key_len/init_key changes during busy SHALL not affect the run.
REQ-026 rk_ready while rk_valid=0 SHALL be ignored.

Reset
REQ-027 Reset SHALL force IDLE; rk_valid=0, rk_last=0, busy=0, err=0, rk_idx=0, round_key=0, counters 0; window zeroed if RST_KEY_CLEAR.
REQ-028 Reset mid-run (GEN or HOLD) SHALL abort with no further rk_valid until a new start.

Structure
REQ-029 Shared package aes_pkg SHALL hold key-length encodings, Nk/Nr lookup constants, rotword and xtime functions.
REQ-030 One sub-module aes_sbox (8-bit combinational S-box) SHALL be instantiated 4 times to form SubWord; no other hierarchy.

Verification
REQ-031 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, 11 keys total.
REQ-032 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk1=62f8ead2522c6b7bfe0c91f72402f5a5, rk12=e98ba06f448c773c8ecc720401002202, 13 keys.
REQ-033 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk2=9ba354118e6925afa51a8b5f2067fcde, rk14=fe4890d1e6188d0b046df344706c631e, 15 keys.
REQ-034 AES-256 run with random rk_ready backpressure (stall up to 7 cycles) -> identical key sequence, round_key stable during stalls, start pulses while busy ignored.
REQ-035 start with key_len=3 -> err single pulse, busy stays 0; with SUPPORT_192=0, key_len=1 -> same.
REQ-036 rst_n=1 asserted in HOLD at rk_idx=5 -> rk_valid=0 next cycle, IDLE; fresh AES-128 start then yields correct rk0..rk10.
